// File: rtl/fwd_hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared types and helpers for the forwarding / load-use hazard unit.
//   trk_entry_t     : one in-flight write tracked after EX
//   SEL_REGFILE     : forward select value meaning "read the register file"
//   youngest_match(): priority pick of the youngest matching producer stage
// The tracker rd field is sized for the widest supported register address
// so the type does not depend on module parameters; narrower addresses are
// zero-extended on entry.
// -----------------------------------------------------------------------------
package fwd_pkg;

  localparam int REG_AW_MAX  = 8;
  localparam int STAGES_MAX  = 15;
  localparam int SEL_W_MAX   = 4;
  localparam int SEL_REGFILE = 0;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  memread;
    logic [REG_AW_MAX-1:0] rd;
  } trk_entry_t;

  // Bit k-1 of match is stage k; the smallest set k wins, 0 when none is set.
  function automatic logic [SEL_W_MAX-1:0] youngest_match(
    input logic [STAGES_MAX-1:0] match
  );
    logic [SEL_W_MAX-1:0] sel;
    sel = SEL_W_MAX'(SEL_REGFILE);
    for (int k = STAGES_MAX; k >= 1; k--) begin
      if (match[k-1]) begin
        sel = SEL_W_MAX'(k);
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit_if
// Pipeline-side bundle for the hazard unit.
//   master : pipeline control (drives EX/ID descriptors, consumes decisions)
//   slave  : fwd_hazard_unit
// Signals: ex_valid, ex_regwrite, ex_memread, ex_rd, ex_rs, id_valid, id_rs
//          (to the unit); forward_sel, stall, id_ex_bubble (from the unit).
// With FWD_PERF_CNT_EN defined, stall_cnt and fwd_cnt are also carried.
// -----------------------------------------------------------------------------
interface fwd_hazard_unit_if #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
);

  logic                      ex_valid;
  logic                      ex_regwrite;
  logic                      ex_memread;
  logic [REG_AW-1:0]         ex_rd;
  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [NUM_SRC*SEL_W-1:0]  forward_sel;
  logic                      stall;
  logic                      id_ex_bubble;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]               stall_cnt;
  logic [31:0]               fwd_cnt;

  modport master (
    output ex_valid, ex_regwrite, ex_memread, ex_rd, ex_rs, id_valid, id_rs,
    input  forward_sel, stall, id_ex_bubble, stall_cnt, fwd_cnt
  );

  modport slave (
    input  ex_valid, ex_regwrite, ex_memread, ex_rd, ex_rs, id_valid, id_rs,
    output forward_sel, stall, id_ex_bubble, stall_cnt, fwd_cnt
  );
`else
  modport master (
    output ex_valid, ex_regwrite, ex_memread, ex_rd, ex_rs, id_valid, id_rs,
    input  forward_sel, stall, id_ex_bubble
  );

  modport slave (
    input  ex_valid, ex_regwrite, ex_memread, ex_rd, ex_rs, id_valid, id_rs,
    output forward_sel, stall, id_ex_bubble
  );
`endif

endinterface

// File: rtl/fwd_hazard_unit_chk.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit_chk
// Checker: a forward must never pick a stage where load data is not yet
// available (stage k <= LOAD_LAT holding a load). The load-use stall is what
// keeps this from happening.
//   clk, rst_n  : clock, active-low reset (checks disabled in reset)
//   forward_sel : per-operand forward selects from the unit
//   stage_load  : memread flag of every tracker stage
// -----------------------------------------------------------------------------
module fwd_hazard_unit_chk #(
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  input logic [NUM_SRC*SEL_W-1:0] forward_sel,
  input logic [FWD_STAGES:1]      stage_load
);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
    logic [SEL_W-1:0] sel_s;
    assign sel_s = forward_sel[i*SEL_W +: SEL_W];
    for (genvar k = 1; k <= FWD_STAGES; k++) begin : g_stage
      a_no_pending_load_fwd: assert property (
        @(posedge clk) disable iff (!rst_n)
        !((sel_s == SEL_W'(k)) && (k <= LOAD_LAT) && stage_load[k])
      );
    end
  end

endmodule

// File: rtl/fwd_hazard_unit_tracker.sv
// -----------------------------------------------------------------------------
// fwd_tracker
// Shift register of in-flight writes behind EX. Stage 1 is EX/MEM, stage 2
// MEM/WB, and so on. It never holds: everything after EX is stall-free, so a
// bubble inserted into ID/EX simply shows up here as an invalid entry.
//   clk, rst_n : clock, asynchronous active-low reset (clears every entry)
//   ex_entry   : descriptor of the instruction currently in EX
//   stages     : tracker contents, index k = stage k
// -----------------------------------------------------------------------------
module fwd_tracker
  import fwd_pkg::*;
#(
  parameter int FWD_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  trk_entry_t                   ex_entry,
  output trk_entry_t [FWD_STAGES:1]    stages
);

  trk_entry_t [FWD_STAGES:1] stages_r;

  // Advance every entry by one stage per clock, EX enters at stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages_r <= '0;
    end else begin
      stages_r[1] <= ex_entry;
      for (int k = 2; k <= FWD_STAGES; k++) begin
        stages_r[k] <= stages_r[k-1];
      end
    end
  end

  assign stages = stages_r;

endmodule

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
// Forwarding and load-use hazard detection for the pipelined MIPS core.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   hz    : fwd_hazard_unit_if.slave
//     in : ex_valid, ex_regwrite, ex_memread, ex_rd, ex_rs (EX instruction)
//          id_valid, id_rs (IF/ID instruction)
//     out: forward_sel  per operand 0 = register file, k = stage k
//          stall        hold PC and IF/ID
//          id_ex_bubble load a bubble into ID/EX on the next edge
// Optional build macro FWD_PERF_CNT_EN adds hz.stall_cnt (stall cycles) and
// hz.fwd_cnt (forwarded operands), both 32-bit wrapping counters.
// forward_sel / stall are combinational: they steer the EX operand muxes and
// the IF/ID enables in the same cycle.
// -----------------------------------------------------------------------------
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_unit_if.slave hz
);

  // Elaboration-time parameter checks.
  if (FWD_STAGES < 2 || FWD_STAGES > STAGES_MAX) begin : g_bad_stages
    $error("fwd_hazard_unit: FWD_STAGES out of range");
  end
  if (LOAD_LAT < 1 || LOAD_LAT >= FWD_STAGES) begin : g_bad_load_lat
    $error("fwd_hazard_unit: LOAD_LAT must be in 1..FWD_STAGES-1");
  end
  if (NUM_SRC < 1) begin : g_bad_num_src
    $error("fwd_hazard_unit: NUM_SRC must be at least 1");
  end
  if (REG_AW < 1 || REG_AW > REG_AW_MAX || SEL_W > SEL_W_MAX) begin : g_bad_width
    $error("fwd_hazard_unit: REG_AW or SEL_W exceeds package limits");
  end

  trk_entry_t                       ex_entry_s;
  trk_entry_t [FWD_STAGES:1]        stages_s;
  logic [NUM_SRC-1:0][STAGES_MAX-1:0] fwd_match_s;
  logic [NUM_SRC*SEL_W-1:0]         forward_sel_s;
  logic                             stall_s;
  logic [FWD_STAGES:1]              stage_load_s;

  // A producer writes register r when it is real, writes, and r is not r0.
  function automatic logic writes_reg(input trk_entry_t e, input logic [REG_AW-1:0] r);
    return e.valid & e.regwrite & (e.rd != '0) & (e.rd == REG_AW_MAX'(r));
  endfunction

  // A load whose result any ID source operand still needs.
  function automatic logic load_blocks_id(
    input trk_entry_t                e,
    input logic                      id_valid,
    input logic [NUM_SRC*REG_AW-1:0] id_rs
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit = hit | writes_reg(e, id_rs[i*REG_AW +: REG_AW]);
    end
    return hit & e.memread & id_valid;
  endfunction

  assign ex_entry_s = '{
    valid:    hz.ex_valid,
    regwrite: hz.ex_regwrite,
    memread:  hz.ex_memread,
    rd:       REG_AW_MAX'(hz.ex_rd)
  };

  fwd_tracker #(
    .FWD_STAGES (FWD_STAGES)
  ) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .ex_entry (ex_entry_s),
    .stages   (stages_s)
  );

  // Per operand: flag matching stages, then take the youngest one.
  always_comb begin
    fwd_match_s   = '0;
    forward_sel_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        fwd_match_s[i][k-1] = writes_reg(stages_s[k], hz.ex_rs[i*REG_AW +: REG_AW]);
      end
      forward_sel_s[i*SEL_W +: SEL_W] = SEL_W'(youngest_match(fwd_match_s[i]));
    end
  end

  // Load-use: OR over EX (j = 0) and tracker stages j < LOAD_LAT. A younger
  // non-load write of the same rd does not cancel this; the stall is
  // deliberately conservative.
  always_comb begin
    stall_s = load_blocks_id(ex_entry_s, hz.id_valid, hz.id_rs);
    for (int j = 1; j < LOAD_LAT; j++) begin
      stall_s = stall_s | load_blocks_id(stages_s[j], hz.id_valid, hz.id_rs);
    end
  end

  assign hz.forward_sel  = forward_sel_s;
  assign hz.stall        = stall_s;
  assign hz.id_ex_bubble = stall_s;

  // Gather the per-stage load flags for the checker.
  always_comb begin
    stage_load_s = '0;
    for (int k = 1; k <= FWD_STAGES; k++) begin
      stage_load_s[k] = stages_s[k].memread;
    end
  end

  fwd_hazard_unit_chk #(
    .NUM_SRC    (NUM_SRC),
    .FWD_STAGES (FWD_STAGES),
    .LOAD_LAT   (LOAD_LAT),
    .SEL_W      (SEL_W)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .forward_sel (forward_sel_s),
    .stage_load  (stage_load_s)
  );

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] fwd_cnt_r;
  logic [31:0] fwd_inc_s;

  // Number of operands taking a forwarded value this cycle.
  always_comb begin
    fwd_inc_s = 32'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_inc_s = fwd_inc_s + 32'(forward_sel_s[i*SEL_W +: SEL_W] != '0);
    end
  end

  // Free-running wrapping performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'd0;
      fwd_cnt_r   <= 32'd0;
    end else begin
      stall_cnt_r <= stall_cnt_r + {31'd0, stall_s};
      fwd_cnt_r   <= fwd_cnt_r + fwd_inc_s;
    end
  end

  assign hz.stall_cnt = stall_cnt_r;
  assign hz.fwd_cnt   = fwd_cnt_r;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
// Directed scoreboard bench. dut0 uses the default configuration, dut1 uses
// LOAD_LAT=2 / FWD_STAGES=3. Stimulus drives inputs just after each rising
// edge and queues the hand-computed outputs for that cycle; the monitor pops
// and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.REG_AW(5), .NUM_SRC(2), .FWD_STAGES(2), .SEL_W(2)) if0 ();
  fwd_hazard_unit_if #(.REG_AW(5), .NUM_SRC(2), .FWD_STAGES(3), .SEL_W(2)) if1 ();

  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .FWD_STAGES(2), .LOAD_LAT(1), .SEL_W(2)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if0)
  );

  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .FWD_STAGES(3), .LOAD_LAT(2), .SEL_W(2)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if1)
  );

  typedef struct packed {
    int         step;
    logic [3:0] sel;
    logic       stall;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  task automatic compare(input int d, input exp_t e, input logic [3:0] sel,
                         input logic st, input logic bb);
    checks++;
    if (sel !== e.sel) begin
      errors++;
      $display("FAIL forward_sel dut%0d step%0d: got %b want %b", d, e.step, sel, e.sel);
    end
    checks++;
    if (st !== e.stall) begin
      errors++;
      $display("FAIL stall dut%0d step%0d: got %b want %b", d, e.step, st, e.stall);
    end
    checks++;
    if (bb !== e.stall) begin
      errors++;
      $display("FAIL id_ex_bubble dut%0d step%0d: got %b want %b", d, e.step, bb, e.stall);
    end
  endtask

  // Monitor: one expectation per DUT per cycle, sampled mid-cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      compare(0, e, if0.forward_sel, if0.stall, if0.id_ex_bubble);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      compare(1, e, if1.forward_sel, if1.stall, if1.id_ex_bubble);
    end
  end

  task automatic idle();
    if0.ex_valid = 1'b0; if0.ex_regwrite = 1'b0; if0.ex_memread = 1'b0;
    if0.ex_rd = 5'd0; if0.ex_rs = 10'd0; if0.id_valid = 1'b0; if0.id_rs = 10'd0;
    if1.ex_valid = 1'b0; if1.ex_regwrite = 1'b0; if1.ex_memread = 1'b0;
    if1.ex_rd = 5'd0; if1.ex_rs = 10'd0; if1.id_valid = 1'b0; if1.id_rs = 10'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step++;
    idle();
  endtask

  task automatic ex(input int d, input logic v, input logic rw, input logic mr,
                    input logic [4:0] rd, input logic [4:0] rs0, input logic [4:0] rs1);
    if (d == 0) begin
      if0.ex_valid = v; if0.ex_regwrite = rw; if0.ex_memread = mr;
      if0.ex_rd = rd; if0.ex_rs = {rs1, rs0};
    end else begin
      if1.ex_valid = v; if1.ex_regwrite = rw; if1.ex_memread = mr;
      if1.ex_rd = rd; if1.ex_rs = {rs1, rs0};
    end
  endtask

  task automatic id(input int d, input logic v, input logic [4:0] rs0, input logic [4:0] rs1);
    if (d == 0) begin
      if0.id_valid = v; if0.id_rs = {rs1, rs0};
    end else begin
      if1.id_valid = v; if1.id_rs = {rs1, rs0};
    end
  endtask

  task automatic expect_o(input int d, input logic [1:0] s0, input logic [1:0] s1,
                          input logic st);
    exp_t e;
    e.step  = step;
    e.sel   = {s1, s0};
    e.stall = st;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    // Reset state.
    tick(); expect_o(0, 2'd0, 2'd0, 1'b0); expect_o(1, 2'd0, 2'd0, 1'b0);
    tick(); rst_n = 1'b1;

    // dut0: add r3 then consumer -> stage 1.
    tick(); ex(0, 1, 1, 0, 5'd3, 5'd1, 5'd2); id(0, 1, 5'd3, 5'd4); expect_o(0, 2'd0, 2'd0, 1'b0);
    tick(); ex(0, 1, 1, 0, 5'd6, 5'd3, 5'd4);                      expect_o(0, 2'd1, 2'd0, 1'b0);
    // add r3, nop, consumer -> stage 2.
    tick(); ex(0, 1, 1, 0, 5'd3, 5'd1, 5'd2);                      expect_o(0, 2'd0, 2'd0, 1'b0);
    tick(); ex(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);                      expect_o(0, 2'd0, 2'd0, 1'b0);
    tick(); ex(0, 1, 1, 0, 5'd7, 5'd3, 5'd5);                      expect_o(0, 2'd2, 2'd0, 1'b0);
    // r3 written in stages 1 and 2 -> youngest (1).
    tick(); ex(0, 1, 1, 0, 5'd3, 5'd8, 5'd9);                      expect_o(0, 2'd0, 2'd0, 1'b0);
    tick(); ex(0, 1, 1, 0, 5'd3, 5'd10, 5'd11);                    expect_o(0, 2'd0, 2'd0, 1'b0);
    tick(); ex(0, 1, 1, 0, 5'd12, 5'd3, 5'd7);                     expect_o(0, 2'd1, 2'd0, 1'b0);
    // Load-use: lw r5 in EX, consumer of r5 in ID -> one stall cycle.
    tick(); ex(0, 1, 1, 1, 5'd5, 5'd1, 5'd0); id(0, 1, 5'd2, 5'd5); expect_o(0, 2'd0, 2'd0, 1'b1);
    tick(); id(0, 1, 5'd2, 5'd5);                                  expect_o(0, 2'd0, 2'd0, 1'b0);
    tick(); ex(0, 1, 1, 0, 5'd13, 5'd2, 5'd5);                     expect_o(0, 2'd0, 2'd2, 1'b0);
    // Writes to r0, including lw r0: never forward, never stall.
    tick(); ex(0, 1, 1, 1, 5'd0, 5'd0, 5'd0); id(0, 1, 5'd0, 5'd0); expect_o(0, 2'd0, 2'd0, 1'b0);
    tick(); ex(0, 1, 1, 0, 5'd0, 5'd0, 5'd0); id(0, 1, 5'd0, 5'd0); expect_o(0, 2'd0, 2'd0, 1'b0);
    tick(); ex(0, 1, 1, 0, 5'd14, 5'd0, 5'd0); id(0, 1, 5'd0, 5'd0); expect_o(0, 2'd0, 2'd0, 1'b0);
    // Load with ID empty: no stall. Non-writing producer: no forward.
    tick(); ex(0, 1, 1, 1, 5'd5, 5'd0, 5'd0); id(0, 0, 5'd0, 5'd5); expect_o(0, 2'd0, 2'd0, 1'b0);
    tick(); ex(0, 1, 0, 0, 5'd3, 5'd0, 5'd0);                      expect_o(0, 2'd0, 2'd0, 1'b0);
    tick(); ex(0, 1, 1, 0, 5'd15, 5'd3, 5'd5);                     expect_o(0, 2'd0, 2'd2, 1'b0);
    // Squashed (invalid) producer of r4 must not forward.
    tick(); ex(0, 0, 1, 0, 5'd4, 5'd0, 5'd0);                      expect_o(0, 2'd0, 2'd0, 1'b0);
    tick(); ex(0, 1, 1, 0, 5'd16, 5'd4, 5'd15);                    expect_o(0, 2'd0, 2'd2, 1'b0);

    // dut1 (LOAD_LAT=2): two stall cycles, then forward from stage 3.
    tick(); ex(1, 1, 1, 1, 5'd5, 5'd1, 5'd0); id(1, 1, 5'd2, 5'd5); expect_o(1, 2'd0, 2'd0, 1'b1);
    tick(); id(1, 1, 5'd2, 5'd5);                                  expect_o(1, 2'd0, 2'd0, 1'b1);
    tick(); id(1, 1, 5'd2, 5'd5);                                  expect_o(1, 2'd0, 2'd0, 1'b0);
    tick(); ex(1, 1, 1, 0, 5'd13, 5'd2, 5'd5);                     expect_o(1, 2'd0, 2'd3, 1'b0);

    // Reset mid-stall with EX driven to bubbles.
    tick(); ex(1, 1, 1, 1, 5'd9, 5'd1, 5'd0); id(1, 1, 5'd9, 5'd0); expect_o(1, 2'd0, 2'd0, 1'b1);
    tick(); rst_n = 1'b0;
            ex(1, 0, 0, 0, 5'd0, 5'd9, 5'd0); id(1, 1, 5'd9, 5'd0);
            expect_o(1, 2'd0, 2'd0, 1'b0); expect_o(0, 2'd0, 2'd0, 1'b0);
    tick(); rst_n = 1'b1;
            ex(0, 1, 1, 0, 5'd3, 5'd9, 5'd0); ex(1, 1, 1, 0, 5'd3, 5'd9, 5'd0);
            expect_o(0, 2'd0, 2'd0, 1'b0); expect_o(1, 2'd0, 2'd0, 1'b0);
    tick(); ex(0, 1, 1, 0, 5'd20, 5'd3, 5'd0); ex(1, 1, 1, 0, 5'd20, 5'd3, 5'd0);
            expect_o(0, 2'd1, 2'd0, 1'b0); expect_o(1, 2'd1, 2'd0, 1'b0);

    tick();
    begin
      int waited;
      waited = 0;
      while ((q0.size() != 0 || q1.size() != 0) && waited < 20) begin
        @(posedge clk);
        waited++;
      end
      if (q0.size() != 0 || q1.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL drain: %0d/%0d expectations left, want 0", q0.size(), q1.size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the pipelined MIPS core. It tracks in-flight register writes in an internal shift register of FWD_STAGES post-EX stages. For each of NUM_SRC source operands of the instruction in EX, it selects the youngest matching producer stage. It also raises a load-use stall, of LOAD_LAT cycles, to the IF/ID stage, and inserts a bubble into ID/EX.

Parameters:
REG_AW, 5, register address width; register 0 is hard-wired zero.
NUM_SRC, 2, source operands per instruction.
FWD_STAGES, 2, post-EX stages that can forward (stage 1 = EX/MEM, stage 2 = MEM/WB, ...).
LOAD_LAT, 1, load data first forwardable from stage LOAD_LAT+1; legal range 1..FWD_STAGES-1.
SEL_W, $clog2(FWD_STAGES+1), width of one forward select.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  ID/EX holds a real instruction (0 = bubble)
ex_regwrite  in  1  EX instruction writes rd
ex_memread  in  1  EX instruction is a load
ex_rd  in  REG_AW  EX destination register
ex_rs  in  NUM_SRC*REG_AW  EX source registers, operand i at [i*REG_AW +: REG_AW]
id_valid  in  1  IF/ID holds a real instruction
id_rs  in  NUM_SRC*REG_AW  ID source registers, same packing as ex_rs
forward_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, k = forward from stage k
stall  out  1  hold PC and IF/ID
id_ex_bubble  out  1  load a bubble into ID/EX next edge

Behaviour:
- Tracker: FWD_STAGES entries {valid, regwrite, memread, rd}.
  - Every clock edge: entry 1 <= EX inputs, with valid = ex_valid; entry k <= entry k-1.
  - The tracker never stalls, because the pipeline after EX is stall-free.
- Reset: all entries cleared asynchronously to 0.
  - While the tracker is empty and ex_valid=0: forward_sel=0, stall=0, id_ex_bubble=0.
- Forwarding (combinational from tracker and ex_rs):
  - A stage k "matches" operand i when valid & regwrite & rd==ex_rs[i] & rd!=0.
  - forward_sel[i] is the smallest matching k; priority goes to the youngest producer.
  - If no stage matches: forward_sel[i]=0. The zero-latency result is 0 for operand register 0.
- Load-use hazard (combinational):
  - A producer at tracker stage j (j=0 means the EX inputs) needs LOAD_LAT-j more cycles when all of the following hold: it is a valid load with regwrite, rd!=0, rd matches any id_rs[i], id_valid=1, and j<LOAD_LAT.
  - stall=1 whenever any such producer exists.
  - id_ex_bubble = stall.
  - Stall repeats each cycle until the load reaches stage LOAD_LAT+1 relative to consumer entry. The load advances one stage per cycle while the bubbles fill behind it.
- Ordering and simultaneous events:
  - Multiple producers: the youngest determines forwarding.
  - Stall is the OR over all producers.
  - A non-load younger write of the same rd masks an older load for forwarding. It still does not cancel that load's stall; the stall is conservative and this is accepted.
- No forward ever selects a load stage k<=LOAD_LAT. The stall guarantees this, and an assertion checks it.
- Reset mid-stall: stall drops once rst_n falls and the EX inputs are bubbles; no residual state remains.
- Elaboration checks: FWD_STAGES>=2, 1<=LOAD_LAT<FWD_STAGES, NUM_SRC>=1.

Optional Feature:
FWD_PERF_CNT_EN: adds two outputs.
- stall_cnt (32 bits): increments on each cycle with stall=1.
- fwd_cnt (32 bits): increments by the number of operands with forward_sel!=0.
- Both counters are asynchronously reset to 0 and wrap at 2^32.
Without the macro, these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
Package fwd_pkg holds:
- typedef trk_entry_t {valid, regwrite, memread, rd}
- constant SEL_REGFILE = 0
- function youngest_match() used by the forwarding priority logic
Sub-module fwd_tracker holds the FWD_STAGES shift register with async reset. The top level holds the match, priority and stall logic.

Test Plan:
- Defaults. Cycle A: EX = add r3 (valid, regwrite=1). Cycle B: EX = sub with rs0=r3. Expect forward_sel[0]=1, [1]=0, stall=0.
- Defaults. add r3 enters EX, then a nop, then a consumer of r3. Expect forward_sel[0]=2. With write r3 in both stage 1 and stage 2, expect 1.
- Defaults, load-use. EX = lw r5, ID rs1=r5. Expect stall=1 and id_ex_bubble=1 for exactly 1 cycle. Next cycle the consumer is in EX with forward_sel[1]=2.
- LOAD_LAT=2, FWD_STAGES=3. Same lw r5 / consumer pair. Expect stall for 2 cycles, then forward_sel=3.
- Writes to r0 (regwrite=1, rd=0), including a lw r0: forward_sel=0 and stall=0 for any rs=r0.
- Assert rst_n low mid-stall with the EX inputs driven to bubbles. Expect the tracker to clear, stall=0, forward_sel=0. After release, a new add r3 / consumer pair forwards from stage 1.
